// File: rtl/code_lock.sv
// code_lock: four-digit push-button combination lock.
//
// Buttons arrive as debounced pulses on BTN. Only their rising edges count,
// so a button held down produces one digit. Four digits are collected and
// compared against CODE, which holds the first digit in its top two bits.
// A correct code raises UNLOCK for UNLOCK_CYCLES cycles. A wrong code pulses
// ERR and bumps FAIL_CNT. MAX_FAIL wrong codes in a row raise LOCKED for
// LOCKOUT_CYCLES cycles. Digit entry gives up after TIMEOUT quiet cycles.
//
// Ports
//   CLK      in   clock, all state on its rising edge
//   RST      in   asynchronous active-high reset
//   BTN      in   [3:0] button pulses, one bit per button
//   UNLOCK   out  high while a correct code is being honoured
//   ERR      out  one-cycle pulse per completed wrong code
//   LOCKED   out  high during lockout
//   FAIL_CNT out  [1:0] consecutive wrong-code count
//   STATE    out  [1:0] 0 idle, 1 entry, 2 open, 3 lockout
module code_lock #(
    parameter logic [7:0] CODE           = 8'b00_01_10_11,
    parameter int         TIMEOUT        = 1000,
    parameter int         UNLOCK_CYCLES  = 200,
    parameter int         MAX_FAIL       = 3,
    parameter int         LOCKOUT_CYCLES = 5000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    output logic       UNLOCK,
    output logic       ERR,
    output logic       LOCKED,
    output logic [1:0] FAIL_CNT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] UN_LAST = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] LK_LAST = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]  FAIL_LIM = 2'(MAX_FAIL);

    state_t      state, state_n;
    logic [3:0]  btn_p;
    logic [31:0] timer, timer_n;
    logic [1:0]  cnt, cnt_n;        // digits already accepted in this entry
    logic        mis, mis_n;        // sticky mismatch for the current entry
    logic [1:0]  fail_cnt, fail_n;
    logic        unlock_r, unlock_n;
    logic        err_r, err_n;
    logic        locked_r, locked_n;

    logic [3:0]  rise;
    logic        btn_evt;
    logic        dig_ok;
    logic [1:0]  digit;
    logic [1:0]  exp_dig;
    logic        dig_bad;
    logic [1:0]  fail_inc;

    assign rise     = BTN & ~btn_p;
    assign btn_evt  = |rise;
    assign fail_inc = fail_cnt + 2'd1;

    // Exactly one rising bit names a digit; any other nonzero pattern is a
    // digit that can never match.
    always_comb begin
        dig_ok = 1'b1;
        digit  = 2'd0;
        unique case (rise)
            4'b0001: digit = 2'd0;
            4'b0010: digit = 2'd1;
            4'b0100: digit = 2'd2;
            4'b1000: digit = 2'd3;
            default: dig_ok = 1'b0;
        endcase
    end

    // cnt is 0 in idle, so the same slice select serves the first digit.
    always_comb begin
        unique case (cnt)
            2'd0:    exp_dig = CODE[7:6];
            2'd1:    exp_dig = CODE[5:4];
            2'd2:    exp_dig = CODE[3:2];
            default: exp_dig = CODE[1:0];
        endcase
    end

    assign dig_bad = !dig_ok || (digit != exp_dig);

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        cnt_n    = cnt;
        mis_n    = mis;
        fail_n   = fail_cnt;
        unlock_n = unlock_r;
        err_n    = 1'b0;
        locked_n = locked_r;
        unique case (state)
            S_IDLE: begin
                if (btn_evt) begin
                    state_n = S_ENTRY;
                    cnt_n   = 2'd1;
                    mis_n   = dig_bad;
                    timer_n = '0;
                end
            end
            S_ENTRY: begin
                if (btn_evt) begin
                    timer_n = '0;
                    if (cnt == 2'd3) begin
                        cnt_n = 2'd0;
                        mis_n = 1'b0;
                        if (!(mis || dig_bad)) begin
                            state_n  = S_OPEN;
                            unlock_n = 1'b1;
                            fail_n   = 2'd0;
                        end else begin
                            err_n  = 1'b1;
                            fail_n = fail_inc;
                            state_n = (fail_inc == FAIL_LIM) ? S_LOCKOUT : S_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 2'd1;
                        mis_n = mis || dig_bad;
                    end
                end else if (timer == TO_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 2'd0;
                    mis_n   = 1'b0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            S_OPEN: begin
                if (timer == UN_LAST) begin
                    state_n  = S_IDLE;
                    unlock_n = 1'b0;
                    timer_n  = '0;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            default: begin
                // The first lockout cycle carries the ERR pulse, so LOCKED
                // rises one cycle later to keep the outputs mutually
                // exclusive; it then holds for the full lockout length.
                if (!locked_r) begin
                    locked_n = 1'b1;
                end else if (timer == LK_LAST) begin
                    state_n  = S_IDLE;
                    locked_n = 1'b0;
                    fail_n   = 2'd0;
                    timer_n  = '0;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            btn_p    <= '0;
            timer    <= '0;
            cnt      <= '0;
            mis      <= 1'b0;
            fail_cnt <= '0;
            unlock_r <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state    <= state_n;
            btn_p    <= BTN;
            timer    <= timer_n;
            cnt      <= cnt_n;
            mis      <= mis_n;
            fail_cnt <= fail_n;
            unlock_r <= unlock_n;
            err_r    <= err_n;
            locked_r <= locked_n;
        end
    end

    assign UNLOCK   = unlock_r;
    assign ERR      = err_r;
    assign LOCKED   = locked_r;
    assign FAIL_CNT = fail_cnt;
    assign STATE    = state;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock with default parameters. Stimulus pushes the expected
// output episodes (kind, start cycle, length, FAIL_CNT) into a queue; a
// monitor retires each UNLOCK / ERR / LOCKED episode as it ends and compares.
module tb_code_lock;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] BTN = 4'b0000;
    logic       UNLOCK, ERR, LOCKED;
    logic [1:0] FAIL_CNT, STATE;

    code_lock dut (
        .CLK(CLK), .RST(RST), .BTN(BTN),
        .UNLOCK(UNLOCK), .ERR(ERR), .LOCKED(LOCKED),
        .FAIL_CNT(FAIL_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;   // 0 ERR, 1 UNLOCK, 2 LOCKED
        int start;
        int len;
        int fc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  excl_viol = 0;
    int  cyc = 0;
    int  pulse_len = 16;
    int  gap_len = 60;
    int  last_s = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic retire(input int k, input int s, input int l, input int f);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_episode kind=%0d start=%0d len=%0d fcnt=%0d, required none", k, s, l, f);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.start != s || e.len != l || e.fc != f) begin
                failures++;
                $display("FAIL episode actual kind=%0d start=%0d len=%0d fcnt=%0d required kind=%0d start=%0d len=%0d fcnt=%0d",
                         k, s, l, f, e.kind, e.start, e.len, e.fc);
            end
        end
    endtask

    // Monitor: episodes are retired when the output drops.
    bit pu = 0, pe = 0, pl = 0;
    int su = 0, se = 0, sl = 0, fu = 0, fe = 0, fl = 0;
    always @(negedge CLK) begin
        if ((int'(UNLOCK) + int'(LOCKED) + int'(ERR)) > 1) excl_viol++;
        if (ERR && !pe) begin se = cyc; fe = int'(FAIL_CNT); end
        if (!ERR && pe) retire(0, se, cyc - se, fe);
        if (UNLOCK && !pu) begin su = cyc; fu = int'(FAIL_CNT); end
        if (!UNLOCK && pu) retire(1, su, cyc - su, fu);
        if (LOCKED && !pl) begin sl = cyc; fl = int'(FAIL_CNT); end
        if (!LOCKED && pl) retire(2, sl, cyc - sl, fl);
        pe = ERR;
        pu = UNLOCK;
        pl = LOCKED;
    end

    // outcome: 0 nothing, 1 unlock of ulen cycles, 2 error, 3 error + lockout
    task automatic press(input logic [3:0] mask, input int outcome, input int fc, input int ulen);
        ev_t e;
        int  s;
        @(negedge CLK);
        s = cyc + 1;
        last_s = s;
        if (outcome == 1) begin
            e.kind = 1; e.start = s; e.len = ulen; e.fc = 0;
            exp_q.push_back(e);
        end else if (outcome >= 2) begin
            e.kind = 0; e.start = s; e.len = 1; e.fc = fc;
            exp_q.push_back(e);
            if (outcome == 3) begin
                e.kind = 2; e.start = s + 1; e.len = 5000; e.fc = fc;
                exp_q.push_back(e);
            end
        end
        BTN = mask;
        repeat (pulse_len) @(negedge CLK);
        BTN = 4'b0000;
        repeat (gap_len) @(negedge CLK);
    endtask

    task automatic code4(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                         input logic [3:0] m3, input int outcome, input int fc, input int ulen);
        press(m0, 0, 0, 0);
        press(m1, 0, 0, 0);
        press(m2, 0, 0, 0);
        press(m3, outcome, fc, ulen);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_unlock"}, int'(UNLOCK), 0);
        chk({tag, "_err"}, int'(ERR), 0);
        chk({tag, "_locked"}, int'(LOCKED), 0);
        chk({tag, "_failcnt"}, int'(FAIL_CNT), 0);
        chk({tag, "_state"}, int'(STATE), 0);
    endtask

    initial begin
        repeat (200000) @(posedge CLK);
        $display("FAIL watchdog cycles=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset state
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Correct code, then presses during OPEN are ignored
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1, 0, 200);
        s = last_s;
        chk("open_state", int'(STATE), 2);
        pulse_len = 4; gap_len = 10;
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, 0, 0);
        pulse_len = 16; gap_len = 60;
        while (cyc < s + 220) @(negedge CLK);
        chk("after_open_state", int'(STATE), 0);

        // Three wrong codes -> lockout
        code4(4'b0001, 4'b0010, 4'b0100, 4'b0100, 2, 1, 0);
        chk("wrong1_failcnt", int'(FAIL_CNT), 1);
        chk("wrong1_state", int'(STATE), 0);
        code4(4'b0001, 4'b0010, 4'b0100, 4'b0100, 2, 2, 0);
        chk("wrong2_failcnt", int'(FAIL_CNT), 2);
        code4(4'b0001, 4'b0010, 4'b0100, 4'b0100, 3, 3, 0);
        s = last_s;
        chk("lockout_state", int'(STATE), 3);
        chk("lockout_failcnt", int'(FAIL_CNT), 3);
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, 0, 0);
        while (cyc < s + 5020) @(negedge CLK);
        chk("after_lockout_failcnt", int'(FAIL_CNT), 0);
        chk("after_lockout_state", int'(STATE), 0);

        // Two buttons rising together on the first digit
        code4(4'b0011, 4'b0010, 4'b0100, 4'b1000, 2, 1, 0);
        chk("multi_failcnt", int'(FAIL_CNT), 1);

        // Timeout mid-entry keeps FAIL_CNT
        press(4'b0001, 0, 0, 0);
        press(4'b0010, 0, 0, 0);
        chk("entry_state", int'(STATE), 1);
        repeat (1000) @(negedge CLK);
        chk("timeout_state", int'(STATE), 0);
        chk("timeout_failcnt", int'(FAIL_CNT), 1);
        press(4'b0100, 0, 0, 0);
        press(4'b1000, 0, 0, 0);
        repeat (1100) @(negedge CLK);
        chk("timeout2_state", int'(STATE), 0);

        // Correct code clears FAIL_CNT
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1, 0, 200);
        s = last_s;
        chk("unlock_clears_failcnt", int'(FAIL_CNT), 0);
        while (cyc < s + 220) @(negedge CLK);

        // Reset during OPEN cuts UNLOCK short
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1, 0, 100);
        s = last_s;
        while (cyc < s + 99) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1 chk_all_zero("rst_open");
        @(posedge CLK);
        #1 RST = 1'b0;

        // Reset after two digits, then a fresh code
        press(4'b0001, 0, 0, 0);
        press(4'b0010, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk_all_zero("rst_entry");
        @(negedge CLK);
        RST = 1'b0;
        code4(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1, 0, 200);
        s = last_s;
        while (cyc < s + 220) @(negedge CLK);

        // Button already high at reset release counts as the first digit
        @(negedge CLK);
        RST = 1'b1;
        BTN = 4'b0001;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("held_btn_state", int'(STATE), 1);
        repeat (15) @(negedge CLK);
        BTN = 4'b0000;
        repeat (60) @(negedge CLK);
        press(4'b0010, 0, 0, 0);
        press(4'b0100, 0, 0, 0);
        press(4'b1000, 1, 0, 200);
        s = last_s;
        while (cyc < s + 220) @(negedge CLK);

        chk("exclusive_outputs_violations", excl_viol, 0);
        chk("scoreboard_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
